sum_uart_tx: RTL

SUM_UART_TX -- requirements
Module: sum_uart_tx

---
 rtl/sum_uart_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sum_uart_tx.sv
// Sum FIFO feeding an 8N1 UART transmitter (8E1 when SUM_UART_PARITY_EN is defined).
// Strobed sums are queued, then framed back-to-back on a registered tx line.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sum_in,
  input  logic       sum_strobe,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SUM_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push_req, push, pop, drop;
  logic [7:0]    head;

  // Transmitter
  state_t        state_q, state_d;
  logic [7:0]    baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_done;
`ifdef SUM_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign full     = (count_q == 4'(FIFO_DEPTH));
  assign empty    = (count_q == 4'd0);
  assign head     = mem_q[rd_ptr_q];
  assign push_req = sum_strobe & ena;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sum_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bit_done = (baud_q == 8'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 8'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef SUM_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
`ifdef SUM_UART_PARITY_EN
          par_d   = ^head;
`endif
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SUM_UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          baud_d = '0;
          // Chain straight into the next frame so the line never idles.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
`ifdef SUM_UART_PARITY_EN
            par_d   = ^head;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is a registered image of the current state, lagging it by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
`ifdef SUM_UART_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef SUM_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef SUM_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
